// File: rtl/level_judge.sv
// Level judge for the counting game: compares each completed level's count error
// against a level-dependent tolerance and tracks level, lives and game end.
module level_judge #(
    parameter int DIFF_W        = 5,
    parameter int LEVEL_W       = 4,
    parameter int MAX_LEVEL     = 9,
    parameter int LIVES         = 3,
    parameter int TOL_BASE      = 2,
    parameter int TOL_MIN       = 0,
    parameter int TIGHTEN_SHIFT = 2
) (
    input  logic               Clk100M,
    input  logic               Reset,
    input  logic               newGame,
    input  logic               levelComplete,
    input  logic [DIFF_W-1:0]  difference,
    output logic               incLevel,
    output logic               missPulse,
    output logic               lose,
    output logic               win,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         livesLeft,
    output logic [DIFF_W-1:0]  tolerance,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        LOST = 2'd1,
        WON  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [2:0]           lives_q, lives_d;
    logic                 inc_q, inc_d;
    logic                 miss_q, miss_d;
    logic                 lc_dly_q, lc_dly_d;

    logic                 lc_rise;
    logic                 pass;
    logic [LEVEL_W-1:0]   lvl_sh;
    logic signed [DIFF_W:0] tol_raw;
    logic signed [DIFF_W:0] tol_min_s;

    // Tolerance is computed one bit wider and signed so high levels clamp instead of wrapping.
    always_comb begin
        lvl_sh    = level_q >> TIGHTEN_SHIFT;
        tol_raw   = $signed((DIFF_W+1)'(TOL_BASE)) - $signed((DIFF_W+1)'(lvl_sh));
        tol_min_s = $signed((DIFF_W+1)'(TOL_MIN));
        if (tol_raw < tol_min_s || tol_raw < 0) begin
            tolerance = DIFF_W'(TOL_MIN);
        end else begin
            tolerance = tol_raw[DIFF_W-1:0];
        end
    end

    assign lc_rise = levelComplete & ~lc_dly_q;
    assign pass    = (difference <= tolerance);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        lives_d  = lives_q;
        inc_d    = 1'b0;
        miss_d   = 1'b0;
        lc_dly_d = levelComplete;
        if (newGame) begin
            state_d = PLAY;
            level_d = '0;
            lives_d = 3'(LIVES);
        end else begin
            case (state_q)
                PLAY: begin
                    if (lc_rise) begin
                        if (pass) begin
                            if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                                level_d = level_q + LEVEL_W'(1);
                                inc_d   = 1'b1;
                            end else begin
                                state_d = WON;
                            end
                        end else begin
                            miss_d = 1'b1;
                            if (lives_q > 3'd1) begin
                                lives_d = lives_q - 3'd1;
                            end else begin
                                lives_d = 3'd0;
                                state_d = LOST;
                            end
                        end
                    end
                end
                LOST, WON: begin
                end
                default: begin
                    state_d = PLAY;
                    level_d = '0;
                    lives_d = 3'(LIVES);
                end
            endcase
        end
    end

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state_q  <= PLAY;
            level_q  <= '0;
            lives_q  <= 3'(LIVES);
            inc_q    <= 1'b0;
            miss_q   <= 1'b0;
            lc_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            lives_q  <= lives_d;
            inc_q    <= inc_d;
            miss_q   <= miss_d;
            lc_dly_q <= lc_dly_d;
        end
    end

    assign incLevel  = inc_q;
    assign missPulse = miss_q;
    assign lose      = (state_q == LOST);
    assign win       = (state_q == WON);
    assign level     = level_q;
    assign livesLeft = lives_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_level_judge.sv
// Directed bench for level_judge: one task per scenario, inline comparisons, one summary line.
module tb_level_judge;

    logic       clk;
    logic       rst;
    logic       new_game;
    logic       level_complete;
    logic [4:0] difference;
    logic       inc_level;
    logic       miss_pulse;
    logic       lose;
    logic       win;
    logic [3:0] level;
    logic [2:0] lives_left;
    logic [4:0] tolerance;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int inc_count = 0;
    int miss_count = 0;

    level_judge dut (
        .Clk100M      (clk),
        .Reset        (rst),
        .newGame      (new_game),
        .levelComplete(level_complete),
        .difference   (difference),
        .incLevel     (inc_level),
        .missPulse    (miss_pulse),
        .lose         (lose),
        .win          (win),
        .level        (level),
        .livesLeft    (lives_left),
        .tolerance    (tolerance),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and exclusivity check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (inc_level === 1'b1) inc_count++;
            if (miss_pulse === 1'b1) miss_count++;
            checks++;
            if ((inc_level & miss_pulse) !== 1'b0) begin
                errors++;
                $display("FAIL pulse_exclusive: inc=%b miss=%b required not both high", inc_level, miss_pulse);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe followed by one low cycle; returns pulses seen right after the judging edge.
    task automatic judge(input logic [4:0] d, output logic got_inc, output logic got_miss);
        level_complete = 1'b1;
        difference     = d;
        step();
        got_inc  = inc_level;
        got_miss = miss_pulse;
        level_complete = 1'b0;
        step();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic gi, gm;
        rst = 1'b1;
        new_game = 1'b0;
        level_complete = 1'b0;
        difference = '0;
        #2;
        checks++; if (inc_level !== 1'b0)   begin errors++; $display("FAIL reset_inc: got %b exp 0", inc_level); end
        checks++; if (miss_pulse !== 1'b0)  begin errors++; $display("FAIL reset_miss: got %b exp 0", miss_pulse); end
        checks++; if (lose !== 1'b0)        begin errors++; $display("FAIL reset_lose: got %b exp 0", lose); end
        checks++; if (win !== 1'b0)         begin errors++; $display("FAIL reset_win: got %b exp 0", win); end
        checks++; if (level !== 4'd0)       begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
        checks++; if (lives_left !== 3'd3)  begin errors++; $display("FAIL reset_lives: got %0d exp 3", lives_left); end
        checks++; if (tolerance !== 5'd2)   begin errors++; $display("FAIL reset_tol: got %0d exp 2", tolerance); end
        checks++; if (dbg_state !== 2'd0)   begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
        step();
        rst = 1'b0;
        step();
        // Default pass at level 0 with diff equal to the tolerance.
        judge(5'd2, gi, gm);
        checks++; if (gi !== 1'b1)         begin errors++; $display("FAIL default_inc: got %b exp 1", gi); end
        checks++; if (gm !== 1'b0)         begin errors++; $display("FAIL default_miss: got %b exp 0", gm); end
        checks++; if (inc_level !== 1'b0)  begin errors++; $display("FAIL default_inc_width: got %b exp 0", inc_level); end
        checks++; if (level !== 4'd1)      begin errors++; $display("FAIL default_level: got %0d exp 1", level); end
        checks++; if (lose !== 1'b0)       begin errors++; $display("FAIL default_lose: got %b exp 0", lose); end
    endtask

    task automatic test_tightening();
        logic gi, gm;
        do_new_game();
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL newgame_level: got %0d exp 0", level); end
        for (int i = 0; i < 4; i++) judge(5'd0, gi, gm);
        checks++; if (level !== 4'd4)     begin errors++; $display("FAIL tight_level4: got %0d exp 4", level); end
        checks++; if (tolerance !== 5'd1) begin errors++; $display("FAIL tight_tol: got %0d exp 1", tolerance); end
        judge(5'd2, gi, gm);
        checks++; if (gm !== 1'b1 || gi !== 1'b0) begin errors++; $display("FAIL tight_miss: got inc=%b miss=%b exp inc=0 miss=1", gi, gm); end
        checks++; if (lives_left !== 3'd2) begin errors++; $display("FAIL tight_lives: got %0d exp 2", lives_left); end
        checks++; if (level !== 4'd4)      begin errors++; $display("FAIL tight_retry_level: got %0d exp 4", level); end
        judge(5'd1, gi, gm);
        checks++; if (gi !== 1'b1 || gm !== 1'b0) begin errors++; $display("FAIL tight_pass: got inc=%b miss=%b exp inc=1 miss=0", gi, gm); end
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL tight_level5: got %0d exp 5", level); end
    endtask

    task automatic test_loss();
        logic gi, gm;
        logic [2:0] exp_lives [3];
        exp_lives[0] = 3'd2; exp_lives[1] = 3'd1; exp_lives[2] = 3'd0;
        do_new_game();
        for (int i = 0; i < 3; i++) begin
            judge(5'd31, gi, gm);
            checks++; if (gm !== 1'b1) begin errors++; $display("FAIL loss_miss%0d: got %b exp 1", i, gm); end
            checks++; if (lives_left !== exp_lives[i]) begin errors++; $display("FAIL loss_lives%0d: got %0d exp %0d", i, lives_left, exp_lives[i]); end
            checks++; if (lose !== (i == 2)) begin errors++; $display("FAIL loss_lose%0d: got %b exp %b", i, lose, (i == 2)); end
        end
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL loss_state: got %0d exp 1", dbg_state); end
        judge(5'd0, gi, gm);
        checks++; if (gi !== 1'b0 || gm !== 1'b0) begin errors++; $display("FAIL lost_ignore_pulse: got inc=%b miss=%b exp 0 0", gi, gm); end
        checks++; if (level !== 4'd0 || lives_left !== 3'd0 || lose !== 1'b1) begin
            errors++; $display("FAIL lost_hold: got level=%0d lives=%0d lose=%b exp 0 0 1", level, lives_left, lose);
        end
    endtask

    task automatic test_win();
        logic gi, gm;
        logic [4:0] exp_tol;
        int start_inc;
        do_new_game();
        start_inc = inc_count;
        for (int i = 0; i < 10; i++) begin
            exp_tol = (i < 4) ? 5'd2 : (i < 8) ? 5'd1 : 5'd0;
            checks++; if (tolerance !== exp_tol) begin errors++; $display("FAIL win_tol_l%0d: got %0d exp %0d", i, tolerance, exp_tol); end
            judge(5'd0, gi, gm);
            checks++; if (gi !== (i < 9)) begin errors++; $display("FAIL win_inc_l%0d: got %b exp %b", i, gi, (i < 9)); end
        end
        checks++; if (inc_count - start_inc != 9) begin errors++; $display("FAIL win_inc_count: got %0d exp 9", inc_count - start_inc); end
        checks++; if (win !== 1'b1 || level !== 4'd9) begin errors++; $display("FAIL win_final: got win=%b level=%0d exp 1 9", win, level); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL win_state: got %0d exp 2", dbg_state); end
        judge(5'd31, gi, gm);
        checks++; if (gm !== 1'b0 || lives_left !== 3'd3 || win !== 1'b1) begin
            errors++; $display("FAIL won_hold: got miss=%b lives=%0d win=%b exp 0 3 1", gm, lives_left, win);
        end
    endtask

    task automatic test_held_strobe();
        int start_inc;
        do_new_game();
        start_inc = inc_count;
        level_complete = 1'b1;
        difference = 5'd0;
        for (int i = 0; i < 10; i++) step();
        level_complete = 1'b0;
        step();
        checks++; if (inc_count - start_inc != 1) begin errors++; $display("FAIL held_inc_count: got %0d exp 1", inc_count - start_inc); end
        checks++; if (level !== 4'd1) begin errors++; $display("FAIL held_level: got %0d exp 1", level); end
    endtask

    task automatic test_back_to_back();
        logic gi, gm;
        // Level 1 (tol 2): pass, then fail, then pass with rises two cycles apart.
        judge(5'd1, gi, gm);
        checks++; if (gi !== 1'b1 || level !== 4'd2) begin errors++; $display("FAIL b2b_first: got inc=%b level=%0d exp 1 2", gi, level); end
        judge(5'd3, gi, gm);
        checks++; if (gm !== 1'b1 || lives_left !== 3'd2 || level !== 4'd2) begin
            errors++; $display("FAIL b2b_second: got miss=%b lives=%0d level=%0d exp 1 2 2", gm, lives_left, level);
        end
        judge(5'd2, gi, gm);
        checks++; if (gi !== 1'b1 || level !== 4'd3) begin errors++; $display("FAIL b2b_third: got inc=%b level=%0d exp 1 3", gi, level); end
    endtask

    task automatic test_priority_and_reset();
        logic gi, gm;
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL prio_setup_level: got %0d exp 3", level); end
        new_game = 1'b1;
        level_complete = 1'b1;
        difference = 5'd0;
        step();
        checks++; if (inc_level !== 1'b0 || level !== 4'd0 || lives_left !== 3'd3) begin
            errors++; $display("FAIL prio_newgame: got inc=%b level=%0d lives=%0d exp 0 0 3", inc_level, level, lives_left);
        end
        new_game = 1'b0;
        level_complete = 1'b0;
        step();
        judge(5'd0, gi, gm);
        judge(5'd0, gi, gm);
        judge(5'd9, gi, gm);
        checks++; if (level !== 4'd2 || lives_left !== 3'd2) begin errors++; $display("FAIL areset_setup: got level=%0d lives=%0d exp 2 2", level, lives_left); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (level !== 4'd0 || lives_left !== 3'd3 || inc_level !== 1'b0 || miss_pulse !== 1'b0 || lose !== 1'b0 || win !== 1'b0) begin
            errors++; $display("FAIL async_reset: got level=%0d lives=%0d inc=%b miss=%b lose=%b win=%b exp 0 3 0 0 0 0",
                               level, lives_left, inc_level, miss_pulse, lose, win);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_tightening();
        test_loss();
        test_win();
        test_held_strobe();
        test_back_to_back();
        test_priority_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
